// File: rtl/hyp_cordic_vector.sv
// hyp_cordic_vector: iterative hyperbolic CORDIC in vectoring mode (drives Y to 0, accumulates atanh in Z)
module hyp_cordic_vector #(
  parameter int DWIDTH = 16,
  parameter int FRAC   = 12,
  parameter int NITER  = 14
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DWIDTH-1:0] Xin,
  input  logic signed [DWIDTH-1:0] Yin,
  input  logic signed [DWIDTH-1:0] Zin,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DWIDTH-1:0] Xout,
  output logic signed [DWIDTH-1:0] Zout,
  output logic                     err
);
  localparam int NSTEP = NITER + 1 + (NITER >= 13 ? 1 : 0);
  localparam int CW = $clog2(NSTEP + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [CW-1:0] cnt, sh;
  logic signed [DWIDTH-1:0] x, y, z, t, xs, ys, xn, yn, zn;
  logic signed [DWIDTH:0] xe, ya;
  logic err_n;
  logic signed [DWIDTH-1:0] tab [1:NITER];
  function automatic logic signed [DWIDTH-1:0] atanh_q(input int i);
    real p, q, s;
    p = 1.0;
    for (int k = 0; k < i; k++) p = p / 2.0;
    q = p;
    s = 0.0;
    for (int k = 0; k < 24; k++) begin
      s = s + q / real'(2 * k + 1);
      q = q * p * p;
    end
    for (int k = 0; k < FRAC; k++) s = s * 2.0;
    return DWIDTH'($rtoi(s + 0.5));
  endfunction
  for (genvar i = 1; i <= NITER; i++) begin : g_tab
    localparam logic signed [DWIDTH-1:0] TV = atanh_q(i);
    assign tab[i] = TV;
  end
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  // shift schedule with 4 and 13 repeated, one microrotation, and the domain check
  always_comb begin
    sh = cnt < CW'(4) ? cnt + CW'(1) : cnt <= CW'(13) ? cnt : cnt - CW'(1);
    t = '0;
    for (int k = 1; k <= NITER; k++) if (sh == CW'(k)) t = tab[k];
    xs = x >>> sh;
    ys = y >>> sh;
    xn = y[DWIDTH-1] ? x + ys : x - ys;
    yn = y[DWIDTH-1] ? y + xs : y - xs;
    zn = y[DWIDTH-1] ? z - t : z + t;
    xe = {Xin[DWIDTH-1], Xin};
    ya = Yin[DWIDTH-1] ? -{Yin[DWIDTH-1], Yin} : {Yin[DWIDTH-1], Yin};
    err_n = xe[DWIDTH] || (xe == '0) || (ya >= xe);
  end
  // control FSM and iteration registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      x     <= '0;
      y     <= '0;
      z     <= '0;
      Xout  <= '0;
      Zout  <= '0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          x     <= Xin;
          y     <= Yin;
          z     <= Zin;
          cnt   <= '0;
          err   <= err_n;
          state <= RUN;
        end
        RUN: begin
          x   <= xn;
          y   <= yn;
          z   <= zn;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(NSTEP - 1)) begin
            Xout  <= xn;
            Zout  <= zn;
            state <= DONE;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/hyp_cordic_vector.md
HYP_CORDIC_VECTOR -- requirements
Module: hyp_cordic_vector

Interface
REQ-001 SHALL have parameter DWIDTH, default 16: width of all data ports; signed two's complement.
REQ-002 SHALL have parameter FRAC, default 12: fractional bits of all data ports, so 1.0 = 2^FRAC.
REQ-003 SHALL have parameter NITER, default 14: highest shift index i; 4 <= NITER <= DWIDTH-2.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port in_valid, input, 1 bit: input operand valid.
REQ-007 SHALL have port in_ready, output, 1 bit: block can accept an operand.
REQ-008 SHALL have port Xin, input, DWIDTH bits: initial X.
REQ-009 SHALL have port Yin, input, DWIDTH bits: initial Y.
REQ-010 SHALL have port Zin, input, DWIDTH bits: initial angle accumulator.
REQ-011 SHALL have port out_valid, output, 1 bit: result valid.
REQ-012 SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-013 SHALL have port Xout, output, DWIDTH bits: final X, approximately K_h*sqrt(Xin^2-Yin^2) with K_h ~ 0.8282.
REQ-014 SHALL have port Zout, output, DWIDTH bits: final Z, approximately Zin + atanh(Yin/Xin).
REQ-015 SHALL have port err, output, 1 bit: operand outside the convergence domain; qualified by out_valid.

Function
REQ-016 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-017 SHALL drive in_ready=1 only in IDLE, and out_valid=1 only in DONE.
REQ-018 In IDLE, SHALL accept an operand when in_valid=1: register Xin/Yin/Zin, clear the step counter, and go to RUN.
REQ-019 On accept, SHALL register err=1 if Xin<=0 or |Yin|>=Xin, and err=0 otherwise; the computation proceeds regardless.
REQ-020 SHALL perform one microrotation per RUN cycle using the shift sequence i = 1,2,3,4,4,5,...,13,13,...,NITER.
  - Indices 4 and 13 are repeated when <= NITER.
  - NSTEP = NITER + count of repeats; default NSTEP = 16.
REQ-021 Each microrotation with Y>=0 SHALL compute:
  - X' = X - (Y>>>i)
  - Y' = Y - (X>>>i)
  - Z' = Z + T[i]
REQ-022 Each microrotation with Y<0 SHALL compute:
  - X' = X + (Y>>>i)
  - Y' = Y + (X>>>i)
  - Z' = Z - T[i]
REQ-023 SHALL use arithmetic (sign-extending) right shifts with truncation, and DWIDTH-bit two's-complement wrap; no saturation.
REQ-024 SHALL hold in an internal constant table T[i] = round(atanh(2^-i) * 2^FRAC) for i = 1..NITER; the default T[1] = 2250.
REQ-025 After the NSTEP-th microrotation, SHALL enter DONE with Xout and Zout holding the final X and Z.
  - Latency: accept at edge T gives out_valid=1 after edge T+NSTEP.
REQ-026 In DONE, Xout/Zout/err SHALL remain stable until out_valid && out_ready, then go to IDLE.
REQ-027 The DONE->IDLE transition SHALL take one cycle; in_valid is not accepted in that cycle because in_ready=0, so the minimum spacing between accepts is NSTEP+2 cycles.
REQ-028 in_valid and the input ports SHALL be ignored outside IDLE.
REQ-029 Xout/Zout/err SHALL retain their last value in IDLE and RUN; they are undefined unless out_valid=1.

Reset
REQ-030 On rst=1 at a clock edge, the FSM SHALL go to IDLE and Xout, Zout, err, the step counter, and internal X/Y/Z SHALL clear to 0.
REQ-031 After reset, in_ready=1 and out_valid=0.
REQ-032 rst in RUN or DONE SHALL abort the operation and discard the result; no out_valid follows.
REQ-033 rst SHALL take priority over in_valid and out_ready in the same cycle.

Verification (DWIDTH=16, FRAC=12, NITER=14; tolerance +/-4 LSB)
REQ-034 Xin=4096, Yin=2048, Zin=0 -> out_valid exactly 16 cycles after accept; Zout~2250, Xout~2938, err=0.
REQ-035 Xin=4096, Yin=-2048, Zin=100 -> Zout~-2150, Xout~2938, err=0.
REQ-036 Xin=-4096, Yin=0 -> err=1, out_valid still after 16 cycles; Xin=4096, Yin=4096 -> err=1.
REQ-037 Result in DONE with out_ready=0 for 10 cycles -> out_valid, Xout, and Zout held constant; in_ready=0 throughout; release -> IDLE next cycle.
REQ-038 rst asserted at RUN step 7 -> next cycle in_ready=1, outputs 0, no out_valid; a new operand then completes normally.
REQ-039 in_valid held high continuously with out_ready=1 -> accepts occur every 18 cycles; no operand accepted during RUN.
